matmul_mem: RTL and testbench
=============================

// Module: matmul_mem
// PURPOSE
//  Memory slave directly downstream of the matmul engine. Each cycle it accepts one engine request (mem_req/mem_write/mem_addr/mem_wdata).
//  It returns engine read data in order on mem_rdata/mem_rdata_vld after a fixed pipelined latency.
//  A secondary host port preloads and reads back operands using idle engine cycles.
//  Free-running read/write counters support bandwidth checks.
// PARAMETERS
//  MEM_AW    16  engine/host address width
//  MEM_DW    32  data width
//  DEPTH_AW  10  physical array depth = 2**DEPTH_AW words; addresses use addr[DEPTH_AW-1:0] (upper bits ignored, alias)
//  READ_LAT  2   request-sample to data-valid latency in cycles; legal range 1..8
//  CNT_W     32  width of rd_cnt / wr_cnt
// PORTS
//  clk            in   1         clock, all logic rising-edge
//  rst_n          in   1         asynchronous active-low reset
//  mem_req        in   1         engine request valid, sampled every cycle, no backpressure
//  mem_write      in   1         1=write, 0=read (qualified by mem_req)
//  mem_addr       in   MEM_AW    engine word address
//  mem_wdata      in   MEM_DW    engine write data
//  mem_rdata_vld  out  1         engine read data valid, one-cycle pulse per read
//  mem_rdata      out  MEM_DW    engine read data
//  host_req       in   1         host request, held until granted
//  host_we        in   1         host write enable
//  host_addr      in   MEM_AW    host word address
//  host_wdata     in   MEM_DW    host write data
//  host_gnt       out  1         host request accepted this cycle (combinational)
//  host_rvld      out  1         host read data valid
//  host_rdata     out  MEM_DW    host read data
//  cnt_clr        in   1         synchronous clear of both counters
//  rd_cnt         out  CNT_W     accepted engine reads, wraps modulo 2**CNT_W
//  wr_cnt         out  CNT_W     accepted engine writes, wraps modulo 2**CNT_W
// BEHAVIOUR
//  Reset: mem_rdata_vld, host_rvld and all pipeline valid/tag bits = 0. mem_rdata, host_rdata, rd_cnt and wr_cnt = 0.
//  Reset does not touch the array; contents survive reset.
//  Arbitration:
//  - Engine always wins; an engine request is never stalled or dropped.
//  - host_gnt = host_req & ~mem_req. Host waits while mem_req=1 and is served in the first cycle with mem_req=0.
//  Access: one access per cycle, sampled at edge T.
//  - Write: the array updates at edge T.
//  - Read: the array is read at T, passes through a (READ_LAT-1)-stage valid+tag+data shift pipe, and is presented during cycle T+READ_LAT.
//  - Tag selects mem_rdata_vld vs host_rvld. Only the selected valid pulses; both data busses hold their last value otherwise.
//  - Back-to-back reads produce back-to-back valid pulses in request order; full throughput, 1 per cycle.
//  Ordering: a read sampled in the cycle after a write to the same physical address returns the new data.
//  - No same-cycle read+write exists (single access per cycle).
//  Consecutive engine writes: the engine holds mem_req/mem_write high across cycles. Every sampled cycle is a separate write.
//  - Repeated identical writes are harmless, and each one counts in wr_cnt.
//  Counters:
//  - rd_cnt increments on mem_req&~mem_write; wr_cnt increments on mem_req&mem_write. Host accesses are not counted.
//  - If cnt_clr and an event occur in the same cycle, clear wins and the counter becomes 0.
//  Aliasing: addr and addr+2**DEPTH_AW hit the same word. No error flag.
//  Reset mid-operation: in-flight reads are discarded and no valid pulse appears after rst_n deasserts.
//  - An ungranted host request must be re-presented.
//  X-safety: mem_write/mem_addr/mem_wdata are don't-care when mem_req=0, and the same holds for the host inputs when host_req=0.
// TESTING
//  1 Host writes 0xA5A5_0001 to addr 5, then host reads addr 5 -> host_gnt each cycle; host_rvld exactly READ_LAT cycles after the read grant with 0xA5A5_0001; mem_rdata_vld stays 0.
//  2 Engine reads addr 0..7 on 8 consecutive cycles (preloaded data=addr*3) -> 8 consecutive mem_rdata_vld pulses carrying 0,3,...,21; rd_cnt=8.
//  3 Engine writes 0x1234 to addr 9, then reads addr 9 the next cycle -> mem_rdata=0x1234 at +READ_LAT; wr_cnt=1.
//  4 host_req held while mem_req=1 for 4 cycles -> host_gnt=0 for those 4 cycles, then 1 in the first idle cycle; the engine stream is unaffected.
//  5 Reset pulsed one cycle after an engine read -> no mem_rdata_vld after reset; the word written before reset is still read back intact.
//  6 Preload rd_cnt to 2**CNT_W-1 (CNT_W=4 build) and issue 1 read -> wraps to 0; cnt_clr coincident with a write -> wr_cnt=0.

Source files
------------

// File: rtl/matmul_mem_if.sv
// Engine and host bus bundle for the matmul operand memory.
// The engine port is a fire-and-forget request stream with in-order read
// returns; the host port is a held request with a combinational grant.
interface matmul_mem_if #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32
);

  // Engine side
  logic              mem_req;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_rdata_vld;
  logic [MEM_DW-1:0] mem_rdata;

  // Host side
  logic              host_req;
  logic              host_we;
  logic [MEM_AW-1:0] host_addr;
  logic [MEM_DW-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvld;
  logic [MEM_DW-1:0] host_rdata;

  // Requester view (engine + host driver)
  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata_vld, mem_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvld, host_rdata
  );

  // Memory view
  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata_vld, mem_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvld, host_rdata
  );

endinterface

// File: rtl/matmul_mem.sv
// Operand memory sitting directly behind the matmul engine.
// One access per cycle: the engine always wins, the host fills idle cycles.
// Reads return in order after READ_LAT cycles (legal range 1..8) through a
// valid+tag+data shift pipe; the tag routes each return to the engine or the
// host data bus. Free-running counters track accepted engine reads/writes.
module matmul_mem #(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int DEPTH_AW = 10,
  parameter int READ_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  matmul_mem_if.slave      bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int DEPTH = 1 << DEPTH_AW;

  // ---------------------------------------------------------------------------
  // Access selection
  // ---------------------------------------------------------------------------
  logic                host_gnt;
  logic                acc_req;
  logic                acc_we;
  logic                acc_wr;
  logic                acc_rd;
  logic                acc_host;
  logic [MEM_AW-1:0]   acc_addr;
  logic [MEM_DW-1:0]   acc_wdata;
  logic [DEPTH_AW-1:0] acc_idx;

  // Pick the single access for this cycle; engine has strict priority.
  // NOTE: every output of an always_comb gets a default at the top so no
  // path through the block leaves a value unassigned and infers a latch.
  always_comb begin
    host_gnt  = bus.host_req & ~bus.mem_req;
    acc_req   = bus.mem_req | host_gnt;
    acc_host  = host_gnt;
    acc_we    = bus.host_we;
    acc_addr  = bus.host_addr;
    acc_wdata = bus.host_wdata;
    if (bus.mem_req) begin
      acc_we    = bus.mem_write;
      acc_addr  = bus.mem_addr;
      acc_wdata = bus.mem_wdata;
    end
    // Gate with acc_req so idle-cycle don't-care inputs never reach the array.
    acc_wr = acc_req & acc_we;
    acc_rd = acc_req & ~acc_we;
  end

  // Upper address bits alias onto the physical array.
  assign acc_idx = acc_addr[DEPTH_AW-1:0];

  logic unused_addr_hi;
  generate
    if (MEM_AW > DEPTH_AW) begin : g_addr_hi
      assign unused_addr_hi = ^acc_addr[MEM_AW-1:DEPTH_AW];
    end else begin : g_no_addr_hi
      assign unused_addr_hi = 1'b0;
    end
  endgenerate

  assign bus.host_gnt = host_gnt;

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  logic [MEM_DW-1:0] mem_q [DEPTH];
  logic [MEM_DW-1:0] rd_word;

  // Array write; contents are retained across reset.
  // NOTE: the array has no reset branch - clearing a RAM needs a sweep, and
  // a reset term would stop it mapping onto memory macros.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  // A read in the cycle after a write sees the new word, since the write
  // landed at the previous edge.
  assign rd_word = mem_q[acc_idx];

  // ---------------------------------------------------------------------------
  // Read return pipe: READ_LAT-1 stages, then the output registers
  // ---------------------------------------------------------------------------
  logic              end_vld;
  logic              end_tag;   // 1 = host read, 0 = engine read
  logic [MEM_DW-1:0] end_data;

  generate
    if (READ_LAT > 1) begin : g_pipe
      localparam int N = READ_LAT - 1;

      logic [N-1:0]      vld_q, vld_d;
      logic [N-1:0]      tag_q, tag_d;
      logic [MEM_DW-1:0] data_q [N];
      logic [MEM_DW-1:0] data_d [N];

      // Shift every stage forward by one; stage 0 captures this cycle's read.
      always_comb begin
        vld_d     = '0;
        tag_d     = '0;
        vld_d[0]  = acc_rd;
        tag_d[0]  = acc_host;
        data_d[0] = rd_word;
        for (int i = 1; i < N; i++) begin
          vld_d[i]  = vld_q[i-1];
          tag_d[i]  = tag_q[i-1];
          data_d[i] = data_q[i-1];
        end
      end

      // Valid and tag bits reset so in-flight reads die with reset.
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          tag_q <= '0;
        end else begin
          vld_q <= vld_d;
          tag_q <= tag_d;
        end
      end

      // Data stages only matter when qualified by valid, so they carry no reset.
      always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
          data_q[i] <= data_d[i];
        end
      end

      assign end_vld  = vld_q[N-1];
      assign end_tag  = tag_q[N-1];
      assign end_data = data_q[N-1];
    end else begin : g_no_pipe
      assign end_vld  = acc_rd;
      assign end_tag  = acc_host;
      assign end_data = rd_word;
    end
  endgenerate

  logic              mem_rdata_vld_q, mem_rdata_vld_d;
  logic              host_rvld_q, host_rvld_d;
  logic [MEM_DW-1:0] mem_rdata_q, mem_rdata_d;
  logic [MEM_DW-1:0] host_rdata_q, host_rdata_d;

  // Route the pipe output by tag; each data bus holds until its own next return.
  always_comb begin
    mem_rdata_vld_d = end_vld & ~end_tag;
    host_rvld_d     = end_vld & end_tag;
    mem_rdata_d     = mem_rdata_q;
    host_rdata_d    = host_rdata_q;
    if (mem_rdata_vld_d) begin
      mem_rdata_d = end_data;
    end
    if (host_rvld_d) begin
      host_rdata_d = end_data;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata_vld_q <= 1'b0;
      host_rvld_q     <= 1'b0;
      mem_rdata_q     <= '0;
      host_rdata_q    <= '0;
    end else begin
      mem_rdata_vld_q <= mem_rdata_vld_d;
      host_rvld_q     <= host_rvld_d;
      mem_rdata_q     <= mem_rdata_d;
      host_rdata_q    <= host_rdata_d;
    end
  end

  assign bus.mem_rdata_vld = mem_rdata_vld_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.host_rvld     = host_rvld_q;
  assign bus.host_rdata    = host_rdata_q;

  // ---------------------------------------------------------------------------
  // Bandwidth counters (engine traffic only)
  // ---------------------------------------------------------------------------
  logic             eng_rd_evt;
  logic             eng_wr_evt;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Next counter values; a clear overrides a coincident event.
  always_comb begin
    eng_rd_evt = bus.mem_req & ~bus.mem_write;
    eng_wr_evt = bus.mem_req & bus.mem_write;
    rd_cnt_d   = rd_cnt_q + CNT_W'(eng_rd_evt);
    wr_cnt_d   = wr_cnt_q + CNT_W'(eng_wr_evt);
    if (cnt_clr) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end
  end

  // Counter registers; wrap naturally modulo 2**CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_matmul_mem.sv
// Directed bench for matmul_mem: a per-cycle vector table for host/engine
// traffic and arbitration, then hand sequences for counter wrap/clear,
// aliasing, back-to-back writes and reset with a read in flight.
module tb_matmul_mem;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int DAW = 10;
  localparam int LAT = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cnt_clr;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;

  matmul_mem_if #(.MEM_AW(AW), .MEM_DW(DW)) bus ();

  matmul_mem #(
    .MEM_AW  (AW),
    .MEM_DW  (DW),
    .DEPTH_AW(DAW),
    .READ_LAT(LAT),
    .CNT_W   (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .cnt_clr(cnt_clr),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  // One row = one clock cycle: inputs applied in that cycle and the outputs
  // expected during that same cycle.
  typedef struct packed {
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wd;
    logic          e_gnt;
    logic          e_mvld;
    logic          e_hvld;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t          vecs[$];
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] exp_rd;
  logic [CW-1:0] exp_wr;

  function automatic vec_t mk(input logic m_req, input logic m_we,
                              input logic [AW-1:0] m_addr, input logic [DW-1:0] m_wd,
                              input logic h_req, input logic h_we,
                              input logic [AW-1:0] h_addr, input logic [DW-1:0] h_wd,
                              input logic e_gnt, input logic e_mvld,
                              input logic e_hvld, input logic [DW-1:0] e_data);
    vec_t v;
    v.m_req  = m_req;  v.m_we = m_we; v.m_addr = m_addr; v.m_wd = m_wd;
    v.h_req  = h_req;  v.h_we = h_we; v.h_addr = h_addr; v.h_wd = h_wd;
    v.e_gnt  = e_gnt;  v.e_mvld = e_mvld; v.e_hvld = e_hvld; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.mem_req    = v.m_req;
    bus.mem_write  = v.m_we;
    bus.mem_addr   = v.m_addr;
    bus.mem_wdata  = v.m_wd;
    bus.host_req   = v.h_req;
    bus.host_we    = v.h_we;
    bus.host_addr  = v.h_addr;
    bus.host_wdata = v.h_wd;
  endtask

  task automatic eng(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mem_req   = 1'b1;
    bus.mem_write = we;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.host_req  = 1'b0;
  endtask

  task automatic idle();
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- vector table ------------------------------------------------------
    // Host write 5, host read 5, returns LAT cycles after the read grant.
    vecs.push_back(mk(0,0,0,0, 1,1,5,32'hA5A5_0001, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,5,0,             1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,             0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,             0,0,1,32'hA5A5_0001));
    // Host preload addr i with i*3.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0,0,0,0, 1,1,AW'(i),DW'(i*3), 1,0,0,0));
    // Engine reads 0..7 back to back; returns start two rows later.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,0,AW'(i),0, 0,0,0,0, 0,(i>=2),0,DW'((i-2)*3)));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,0,18));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,0,21));
    // Engine write 9 then read 9 the next cycle.
    vecs.push_back(mk(1,1,9,32'h1234, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,9,0,        0,0,0,0, 0,0,0,0));
    // Host read of 9 held behind 4 engine reads, granted on first idle cycle.
    vecs.push_back(mk(1,0,1,0, 1,0,9,0, 0,0,0,0));
    vecs.push_back(mk(1,0,2,0, 1,0,9,0, 0,1,0,32'h1234));
    vecs.push_back(mk(1,0,3,0, 1,0,9,0, 0,1,0,3));
    vecs.push_back(mk(1,0,4,0, 1,0,9,0, 0,1,0,6));
    vecs.push_back(mk(0,0,0,0, 1,0,9,0, 1,1,0,9));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,0,12));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,32'h1234));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0));

    // ---- reset state -------------------------------------------------------
    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    idle();
    #12;
    check("rst_mem_rdata_vld", DW'(bus.mem_rdata_vld), 0);
    check("rst_host_rvld",     DW'(bus.host_rvld),     0);
    check("rst_mem_rdata",     bus.mem_rdata,          0);
    check("rst_host_rdata",    bus.host_rdata,         0);
    check("rst_rd_cnt",        DW'(rd_cnt),            0);
    check("rst_wr_cnt",        DW'(wr_cnt),            0);
    rst_n = 1'b1;
    step();

    // ---- table run ---------------------------------------------------------
    exp_rd = '0;
    exp_wr = '0;
    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r]);
      #1;
      check($sformatf("row%0d_host_gnt", r),      DW'(bus.host_gnt),      DW'(vecs[r].e_gnt));
      check($sformatf("row%0d_mem_rdata_vld", r), DW'(bus.mem_rdata_vld), DW'(vecs[r].e_mvld));
      check($sformatf("row%0d_host_rvld", r),     DW'(bus.host_rvld),     DW'(vecs[r].e_hvld));
      if (vecs[r].e_mvld)
        check($sformatf("row%0d_mem_rdata", r),   bus.mem_rdata,          vecs[r].e_data);
      if (vecs[r].e_hvld)
        check($sformatf("row%0d_host_rdata", r),  bus.host_rdata,         vecs[r].e_data);
      check($sformatf("row%0d_rd_cnt", r),        DW'(rd_cnt),            DW'(exp_rd));
      check($sformatf("row%0d_wr_cnt", r),        DW'(wr_cnt),            DW'(exp_wr));
      exp_rd = exp_rd + CW'(vecs[r].m_req & ~vecs[r].m_we);
      exp_wr = exp_wr + CW'(vecs[r].m_req & vecs[r].m_we);
      step();
    end

    // Data buses hold their last returned value.
    check("hold_mem_rdata",  bus.mem_rdata,  12);
    check("hold_host_rdata", bus.host_rdata, 32'h1234);

    // ---- counter clear and rd_cnt wrap (CW=4) ------------------------------
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_rd_cnt", DW'(rd_cnt), 0);
    check("clr_wr_cnt", DW'(wr_cnt), 0);
    for (int i = 0; i < 15; i++) begin
      eng(1'b0, '0, '0);
      step();
    end
    idle();
    check("rd_cnt_max", DW'(rd_cnt), 15);
    eng(1'b0, '0, '0);
    step();
    idle();
    check("rd_cnt_wrap", DW'(rd_cnt), 0);

    // ---- aliasing: addr 9+1024 hits word 9 ---------------------------------
    eng(1'b1, 16'h0409, 32'hBEEF);
    step();
    check("alias_wr_cnt", DW'(wr_cnt), 1);
    eng(1'b0, 16'h0009, '0);
    step();
    idle();
    step();
    check("alias_vld",   DW'(bus.mem_rdata_vld), 1);
    check("alias_rdata", bus.mem_rdata,          32'hBEEF);

    // ---- clear coincident with write, then repeated identical writes -------
    eng(1'b1, 16'd20, 32'h5);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_win_wr_cnt", DW'(wr_cnt), 0);
    step();
    step();
    idle();
    check("rep_wr_cnt", DW'(wr_cnt), 2);

    // ---- reset one cycle after an engine read ------------------------------
    eng(1'b1, 16'd30, 32'hCAFE_0030);
    step();
    eng(1'b0, 16'd30, '0);
    step();
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    check("in_rst_vld",    DW'(bus.mem_rdata_vld), 0);
    check("in_rst_rdata",  bus.mem_rdata,          0);
    check("in_rst_rd_cnt", DW'(rd_cnt),            0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst_vld%0d", i),  DW'(bus.mem_rdata_vld), 0);
      check($sformatf("post_rst_hvld%0d", i), DW'(bus.host_rvld),     0);
    end
    eng(1'b0, 16'd30, '0);
    step();
    idle();
    step();
    check("survive_vld",   DW'(bus.mem_rdata_vld), 1);
    check("survive_rdata", bus.mem_rdata,          32'hCAFE_0030);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
